// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_ctrl_pkg
// Description : Shared encodings for the multicycle ARM-subset controller:
//               FSM state codes, ALU control, mux selects, condition codes.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

    // FSM state encodings
    localparam logic [3:0] c_S_FETCH    = 4'd0;
    localparam logic [3:0] c_S_DECODE   = 4'd1;
    localparam logic [3:0] c_S_MEMADR   = 4'd2;
    localparam logic [3:0] c_S_MEMRD    = 4'd3;
    localparam logic [3:0] c_S_MEMWB    = 4'd4;
    localparam logic [3:0] c_S_MEMWR    = 4'd5;
    localparam logic [3:0] c_S_EXECUTER = 4'd6;
    localparam logic [3:0] c_S_EXECUTEI = 4'd7;
    localparam logic [3:0] c_S_ALUWB    = 4'd8;
    localparam logic [3:0] c_S_BRANCH   = 4'd9;

    // ALUControl encodings
    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    // ResultSrc encodings
    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_DATA      = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] c_SRCB_RD2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    // Condition-code field values
    localparam logic [3:0] c_COND_EQ = 4'b0000;
    localparam logic [3:0] c_COND_NE = 4'b0001;
    localparam logic [3:0] c_COND_CS = 4'b0010;
    localparam logic [3:0] c_COND_CC = 4'b0011;
    localparam logic [3:0] c_COND_MI = 4'b0100;
    localparam logic [3:0] c_COND_PL = 4'b0101;
    localparam logic [3:0] c_COND_VS = 4'b0110;
    localparam logic [3:0] c_COND_VC = 4'b0111;
    localparam logic [3:0] c_COND_HI = 4'b1000;
    localparam logic [3:0] c_COND_LS = 4'b1001;
    localparam logic [3:0] c_COND_GE = 4'b1010;
    localparam logic [3:0] c_COND_LT = 4'b1011;
    localparam logic [3:0] c_COND_GT = 4'b1100;
    localparam logic [3:0] c_COND_LE = 4'b1101;
    localparam logic [3:0] c_COND_AL = 4'b1110;
    localparam logic [3:0] c_COND_NV = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/arm_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : arm_cond_unit
// Description : NZCV flags register, condition evaluation and the per-
//               instruction registered condition result used to gate writes.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       i_latch_en,
    output logic       o_cond_ex_reg
);

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign o_cond_ex_reg        = r_cond_ex;

    // Evaluate the instruction's condition field against the stored flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            c_COND_EQ: w_cond_ex = w_z;
            c_COND_NE: w_cond_ex = ~w_z;
            c_COND_CS: w_cond_ex = w_c;
            c_COND_CC: w_cond_ex = ~w_c;
            c_COND_MI: w_cond_ex = w_n;
            c_COND_PL: w_cond_ex = ~w_n;
            c_COND_VS: w_cond_ex = w_v;
            c_COND_VC: w_cond_ex = ~w_v;
            c_COND_HI: w_cond_ex = w_c & ~w_z;
            c_COND_LS: w_cond_ex = ~w_c | w_z;
            c_COND_GE: w_cond_ex = (w_n == w_v);
            c_COND_LT: w_cond_ex = (w_n != w_v);
            c_COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            c_COND_LE: w_cond_ex = w_z | (w_n != w_v);
            c_COND_AL: w_cond_ex = 1'b1;
            default:   w_cond_ex = 1'b0;
        endcase
    end

    // Flags register; N/Z and C/V halves are written independently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= RESET_FLAGS;
        end else begin
            if (FlagW[1] & r_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & r_cond_ex) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Capture the condition outcome once per instruction, held until next decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond_ex <= 1'b0;
        end else if (i_latch_en) begin
            r_cond_ex <= w_cond_ex;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : arm_multicycle_controller
// Description : Multicycle control FSM and ALU decoder for the ARM-subset
//               datapath; drives mux selects and condition-gated enables.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_eff_state;
    logic       w_ir_write;
    logic       w_next_pc;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_alu_op;
    logic [1:0] w_flag_w;
    logic       w_pcs;
    logic       w_cond_ex_reg;
    logic       w_latch_en;

    // While reset is held the decoded controls show the FETCH values
    assign w_eff_state = reset ? c_S_FETCH : r_state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state selection
    always_comb begin
        w_next_state = c_S_FETCH;
        case (r_state)
            c_S_FETCH:  w_next_state = c_S_DECODE;
            c_S_DECODE: begin
                case (Op)
                    2'b00:   w_next_state = Funct[5] ? c_S_EXECUTEI : c_S_EXECUTER;
                    2'b01:   w_next_state = c_S_MEMADR;
                    2'b10:   w_next_state = c_S_BRANCH;
                    default: w_next_state = c_S_FETCH;
                endcase
            end
            c_S_MEMADR:   w_next_state = Funct[0] ? c_S_MEMRD : c_S_MEMWR;
            c_S_MEMRD:    w_next_state = c_S_MEMWB;
            c_S_EXECUTER: w_next_state = c_S_ALUWB;
            c_S_EXECUTEI: w_next_state = c_S_ALUWB;
            default:      w_next_state = c_S_FETCH;
        endcase
    end

    // Per-state datapath controls (ungated)
    always_comb begin
        w_ir_write = 1'b0;
        w_next_pc  = 1'b0;
        w_reg_w    = 1'b0;
        w_mem_w    = 1'b0;
        w_branch   = 1'b0;
        w_alu_op   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = c_SRCB_RD2;
        ResultSrc  = c_RES_ALUOUT;
        case (w_eff_state)
            c_S_FETCH: begin
                w_ir_write = 1'b1;
                w_next_pc  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = c_SRCB_FOUR;
                ResultSrc  = c_RES_ALURESULT;
            end
            c_S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURESULT;
            end
            c_S_MEMADR: ALUSrcB = c_SRCB_IMM;
            c_S_MEMRD:  AdrSrc  = 1'b1;
            c_S_MEMWB: begin
                ResultSrc = c_RES_DATA;
                w_reg_w   = 1'b1;
            end
            c_S_MEMWR: begin
                AdrSrc  = 1'b1;
                w_mem_w = 1'b1;
            end
            c_S_EXECUTER: w_alu_op = 1'b1;
            c_S_EXECUTEI: begin
                ALUSrcB  = c_SRCB_IMM;
                w_alu_op = 1'b1;
            end
            c_S_ALUWB: w_reg_w = 1'b1;
            c_S_BRANCH: begin
                ALUSrcB   = c_SRCB_IMM;
                ResultSrc = c_RES_ALURESULT;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decode: operation and flag-write mask, active only in execute states
    always_comb begin
        ALUControl = c_ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (Funct[4:1])
                4'b0100: ALUControl = c_ALU_ADD;
                4'b0010: ALUControl = c_ALU_SUB;
                4'b0000: ALUControl = c_ALU_AND;
                4'b1100: ALUControl = c_ALU_ORR;
                default: ALUControl = c_ALU_ADD;
            endcase
            w_flag_w[1] = Funct[0];
            w_flag_w[0] = Funct[0] & ((ALUControl == c_ALU_ADD) | (ALUControl == c_ALU_SUB));
        end
    end

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b10, Op == 2'b01};

    // A write to R15 or a branch redirects the PC
    assign w_pcs      = ((Rd == 4'hF) & w_reg_w) | w_branch;
    assign w_latch_en = (r_state == c_S_DECODE);

    // Write enables are condition-gated and suppressed while in reset
    assign IRWrite  = w_ir_write & ~reset;
    assign RegWrite = w_reg_w & w_cond_ex_reg & ~reset;
    assign MemWrite = w_mem_w & w_cond_ex_reg & ~reset;
    assign PCWrite  = (w_next_pc | (w_pcs & w_cond_ex_reg)) & ~reset;

    arm_cond_unit #(
        .RESET_FLAGS (RESET_FLAGS)
    ) u_cond (
        .clk           (clk),
        .reset         (reset),
        .Cond          (Cond),
        .ALUFlags      (ALUFlags),
        .FlagW         (w_flag_w),
        .i_latch_en    (w_latch_en),
        .o_cond_ex_reg (w_cond_ex_reg)
    );

endmodule
`default_nettype wire
